multi_debouncer: RTL and testbench

Parametrised N-channel switch/button debouncer with a configurable synchronizer depth, debounce interval and reset level. Each channel produces a debounced level, registered one-cycle rise/fall pulses and an optional hold-to-repeat pulse train. The block sits between raw board inputs (buttons, DIP switches) and control logic such as display multiplexers and counters. It replaces per-button single-channel debouncer instances.

---
 rtl/multi_debouncer_pkg.sv | 17 +
 rtl/multi_debouncer_if.sv | 25 ++
 rtl/multi_debouncer_channel.sv | 86 ++++++++
 rtl/multi_debouncer.sv | 55 +++++
 tb/tb_multi_debouncer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/multi_debouncer_pkg.sv
// Shared defaults and helpers for the multi-channel debouncer.
package multi_debouncer_pkg;

    localparam int unsigned DEF_N_CH        = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_CNT_W       = 17;
    localparam int unsigned DEF_REP_W       = 0;

    // All-ones pattern of the given width, used for saturation/wrap compares.
    function automatic logic [31:0] all_ones(input int unsigned w);
        if (w >= 32) begin
            return '1;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/multi_debouncer_if.sv
// Raw switch inputs and debounced outputs of the multi-channel debouncer.
interface multi_debouncer_if
    import multi_debouncer_pkg::*;
#(
    parameter int unsigned N_CH = DEF_N_CH
);

    logic [N_CH-1:0] switch_input;
    logic [N_CH-1:0] state;
    logic [N_CH-1:0] trans_up;
    logic [N_CH-1:0] trans_dn;
    logic [N_CH-1:0] rep;
    logic            any_event;

    modport master (
        output switch_input,
        input  state, trans_up, trans_dn, rep, any_event
    );

    modport slave (
        input  switch_input,
        output state, trans_up, trans_dn, rep, any_event
    );

endinterface

// File: rtl/multi_debouncer_channel.sv
// Single-bit debouncer: synchronizer, stable-interval counter, debounced
// state, registered edge pulses and optional hold-to-repeat pulse train.
module multi_debouncer_channel
    import multi_debouncer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned REP_W       = DEF_REP_W,
    parameter logic        RESET_STATE = 1'b0
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic din,
    output logic state,
    output logic trans_up,
    output logic trans_dn,
    output logic rep
);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   s;
    logic                   mismatch;
    logic                   flip;

    assign s        = sync[SYNC_STAGES-1];
    assign mismatch = (s != state);
    assign flip     = mismatch && (cnt == CNT_W'(all_ones(CNT_W)));

    // Synchronizer chain for the asynchronous raw input.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync <= {SYNC_STAGES{RESET_STATE}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    // Debounce counter, state flip on saturation and edge pulses.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt      <= '0;
            state    <= RESET_STATE;
            trans_up <= 1'b0;
            trans_dn <= 1'b0;
        end else begin
            trans_up <= flip && !state;
            trans_dn <= flip && state;
            if (flip) begin
                state <= ~state;
                cnt   <= '0;
            end else if (mismatch) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    if (REP_W > 0) begin : g_rep
        logic [REP_W-1:0] rcnt;
        logic             rep_hit;

        assign rep_hit = (rcnt == REP_W'(all_ones(REP_W)));

        // Repeat counter runs only while held high; cleared on the rising
        // flip edge so the first pulse lands a full period after trans_up,
        // and suppressed on the falling flip so it never overlaps trans_dn.
        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                rcnt <= '0;
                rep  <= 1'b0;
            end else begin
                rep <= state && !flip && rep_hit;
                if (!state || flip) begin
                    rcnt <= '0;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end
        end
    end else begin : g_no_rep
        assign rep = 1'b0;
    end

endmodule

// File: rtl/multi_debouncer.sv
// N-channel switch debouncer: one channel instance per input bit plus a
// registered any_event summary of all pulses.
module multi_debouncer
    import multi_debouncer_pkg::*;
#(
    parameter int unsigned N_CH        = DEF_N_CH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned REP_W       = DEF_REP_W,
    parameter logic        RESET_STATE = 1'b0
) (
    input logic              CLK,
    input logic              RST_N,
    multi_debouncer_if.slave bus
);

    logic [N_CH-1:0] state_v;
    logic [N_CH-1:0] up_v;
    logic [N_CH-1:0] dn_v;
    logic [N_CH-1:0] rep_v;
    logic            any_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        multi_debouncer_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .REP_W       (REP_W),
            .RESET_STATE (RESET_STATE)
        ) u_ch (
            .CLK      (CLK),
            .RST_N    (RST_N),
            .din      (bus.switch_input[i]),
            .state    (state_v[i]),
            .trans_up (up_v[i]),
            .trans_dn (dn_v[i]),
            .rep      (rep_v[i])
        );
    end

    // One-cycle-delayed OR of every registered pulse on every channel.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |(up_v | dn_v | rep_v);
        end
    end

    assign bus.state     = state_v;
    assign bus.trans_up  = up_v;
    assign bus.trans_dn  = dn_v;
    assign bus.rep       = rep_v;
    assign bus.any_event = any_q;

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed self-checking bench for multi_debouncer (N_CH=4, SYNC_STAGES=2,
// CNT_W=4, REP_W=5): state flips 18 edges after first sampling, repeat
// pulses every 32 cycles while held.
module tb_multi_debouncer;

    localparam int unsigned N_CH = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    multi_debouncer_if #(.N_CH(N_CH)) dbg_if ();

    multi_debouncer #(
        .N_CH        (N_CH),
        .SYNC_STAGES (2),
        .CNT_W       (4),
        .REP_W       (5),
        .RESET_STATE (1'b0)
    ) u_dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (dbg_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [N_CH-1:0] acc_up;
    logic [N_CH-1:0] acc_dn;
    logic [N_CH-1:0] acc_rep;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        dbg_if.switch_input = '0;

        // 1. reset, then stable press on ch0
        tick(3);
        check("rst_state", 32'(dbg_if.state), 32'h0);
        check("rst_up", 32'(dbg_if.trans_up), 32'h0);
        check("rst_any", 32'(dbg_if.any_event), 32'h0);
        rst_n = 1'b1;
        dbg_if.switch_input = 4'b0001;
        tick(17);
        check("t1_state_before", 32'(dbg_if.state), 32'h0);
        tick(1);
        check("t1_state_after", 32'(dbg_if.state), 32'h1);
        check("t1_up", 32'(dbg_if.trans_up), 32'h1);
        check("t1_any_same", 32'(dbg_if.any_event), 32'h0);
        tick(1);
        check("t1_up_gone", 32'(dbg_if.trans_up), 32'h0);
        check("t1_any_next", 32'(dbg_if.any_event), 32'h1);

        // 3. release ch0
        dbg_if.switch_input = 4'b0000;
        tick(17);
        check("t3_state_before", 32'(dbg_if.state), 32'h1);
        check("t3_dn_before", 32'(dbg_if.trans_dn), 32'h0);
        tick(1);
        check("t3_state_after", 32'(dbg_if.state), 32'h0);
        check("t3_dn", 32'(dbg_if.trans_dn), 32'h1);
        tick(1);
        check("t3_dn_gone", 32'(dbg_if.trans_dn), 32'h0);
        check("t3_any", 32'(dbg_if.any_event), 32'h1);
        acc_rep = '0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            acc_rep |= dbg_if.rep;
        end
        check("t3_no_rep", 32'(acc_rep), 32'h0);

        // 2. glitch on ch1: high 10, low 2, high and hold
        dbg_if.switch_input = 4'b0010;
        acc_up = '0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            acc_up |= dbg_if.trans_up;
        end
        dbg_if.switch_input = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            acc_up |= dbg_if.trans_up;
        end
        check("t2_glitch_up", 32'(acc_up), 32'h0);
        check("t2_glitch_state", 32'(dbg_if.state), 32'h0);
        dbg_if.switch_input = 4'b0010;
        tick(17);
        check("t2_state_before", 32'(dbg_if.state), 32'h0);
        tick(1);
        check("t2_state_after", 32'(dbg_if.state), 32'h2);
        check("t2_up", 32'(dbg_if.trans_up), 32'h2);
        tick(1);
        check("t2_any", 32'(dbg_if.any_event), 32'h1);
        dbg_if.switch_input = 4'b0000;
        tick(24);
        check("t2_released", 32'(dbg_if.state), 32'h0);

        // 4. auto-repeat on ch2
        dbg_if.switch_input = 4'b0100;
        tick(18);
        check("t4_up", 32'(dbg_if.trans_up), 32'h4);
        acc_rep = '0;
        for (int i = 1; i <= 96; i++) begin
            tick(1);
            if (i % 32 == 0) begin
                check($sformatf("t4_rep_at_%0d", i), 32'(dbg_if.rep), 32'h4);
            end else begin
                acc_rep |= dbg_if.rep;
            end
        end
        check("t4_rep_stray", 32'(acc_rep), 32'h0);
        dbg_if.switch_input = 4'b0000;
        acc_rep = '0;
        for (int i = 1; i <= 18; i++) begin
            tick(1);
            acc_rep |= dbg_if.rep;
            if (i == 18) begin
                check("t4_dn", 32'(dbg_if.trans_dn), 32'h4);
            end
        end
        for (int i = 0; i < 40; i++) begin
            tick(1);
            acc_rep |= dbg_if.rep;
        end
        check("t4_rep_after_release", 32'(acc_rep), 32'h0);
        check("t4_state", 32'(dbg_if.state), 32'h0);

        // 5. ch0 and ch3 rise together
        dbg_if.switch_input = 4'b1001;
        tick(18);
        check("t5_up", 32'(dbg_if.trans_up), 32'h9);
        check("t5_any_same", 32'(dbg_if.any_event), 32'h0);
        tick(1);
        check("t5_up_gone", 32'(dbg_if.trans_up), 32'h0);
        check("t5_any", 32'(dbg_if.any_event), 32'h1);
        tick(1);
        check("t5_any_single", 32'(dbg_if.any_event), 32'h0);
        dbg_if.switch_input = 4'b0000;
        tick(22);
        check("t5_released", 32'(dbg_if.state), 32'h0);

        // 6. reset at count 10 of a ch1 press
        dbg_if.switch_input = 4'b0010;
        tick(12);
        rst_n = 1'b0;
        tick(1);
        check("t6_rst_state", 32'(dbg_if.state), 32'h0);
        check("t6_rst_up", 32'(dbg_if.trans_up), 32'h0);
        check("t6_rst_any", 32'(dbg_if.any_event), 32'h0);
        rst_n = 1'b1;
        acc_up = '0;
        for (int i = 0; i < 17; i++) begin
            tick(1);
            acc_up |= dbg_if.trans_up;
        end
        check("t6_no_early_up", 32'(acc_up), 32'h0);
        check("t6_state_before", 32'(dbg_if.state), 32'h0);
        tick(1);
        check("t6_state_after", 32'(dbg_if.state), 32'h2);
        check("t6_up", 32'(dbg_if.trans_up), 32'h2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
